// File: rtl/imm_packer_if.sv
// ---------------------------------------------------------------------------
// imm_packer_if
//   Request/response bundle for the immediate packer.
//   Request side : in_valid, in_ready, immsrc, imm, base
//   Response side: out_valid, out_ready, instr, err, err_count
//   modport master : the producer/consumer around the packer (drives requests,
//                    accepts packed words)
//   modport slave  : the packer itself
// ---------------------------------------------------------------------------
interface imm_packer_if #(
   parameter int ERRCNT_W = 8
);
   logic                in_valid;
   logic                in_ready;
   logic [1:0]          immsrc;
   logic [31:0]         imm;
   logic [31:0]         base;
   logic                out_valid;
   logic                out_ready;
   logic [31:0]         instr;
   logic                err;
   logic [ERRCNT_W-1:0] err_count;

   modport master (
      output in_valid, immsrc, imm, base, out_ready,
      input  in_ready, out_valid, instr, err, err_count
   );

   modport slave (
      input  in_valid, immsrc, imm, base, out_ready,
      output in_ready, out_valid, instr, err, err_count
   );
endinterface

// File: rtl/imm_packer.sv
// ---------------------------------------------------------------------------
// imm_packer
//   Inverse of the immediate extender: scatters a signed 32-bit immediate
//   into the immediate fields of a base instruction word chosen by immsrc
//   (00 I, 01 S, 10 B, 11 J). Used when building instruction images on-chip.
//
//   Two-stage valid/ready pipeline:
//     stage 1 registers the request and flags immediates the format cannot
//             represent (rerr),
//     stage 2 registers the packed word, which is presented directly on the
//             outputs.
//   Unrepresentable immediates are still packed from their truncated bits
//   and reported with err=1; delivered error words are counted in a
//   saturating counter.
//
// Ports
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset; deassertion is expected to be
//              synchronised to clk by the reset controller
//   bus      : imm_packer_if.slave (request in, packed word out)
// ---------------------------------------------------------------------------
module imm_packer #(
   parameter int ERRCNT_W = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   imm_packer_if.slave bus
);

   localparam logic [1:0] FMT_I = 2'b00;
   localparam logic [1:0] FMT_S = 2'b01;
   localparam logic [1:0] FMT_B = 2'b10;
   localparam logic [1:0] FMT_J = 2'b11;

   localparam logic [ERRCNT_W-1:0] ERR_MAX = {ERRCNT_W{1'b1}};
   localparam logic [ERRCNT_W-1:0] ERR_ONE = {{(ERRCNT_W-1){1'b0}}, 1'b1};

   // An immediate fits a format when every bit above the top encoded bit is a
   // copy of that bit (pure sign extension); B and J additionally have no
   // bit 0 field, so odd values cannot be encoded.
   function automatic logic range_err(input logic [1:0] fmt, input logic [31:0] v);
      logic e;
      case (fmt)
         FMT_I:   e = (v[31:11] != {21{v[11]}});
         FMT_S:   e = (v[31:11] != {21{v[11]}});
         FMT_B:   e = (v[31:12] != {20{v[12]}}) | v[0];
         FMT_J:   e = (v[31:20] != {12{v[20]}}) | v[0];
         default: e = 1'b1;
      endcase
      return e;
   endfunction

   // Overwrite only the immediate fields of the base word; all other bits of
   // base pass through. Only imm[20:0] is ever encoded by any format.
   function automatic logic [31:0] pack(input logic [1:0]  fmt,
                                        input logic [20:0] v,
                                        input logic [31:0] b);
      logic [31:0] w;
      w = b;
      case (fmt)
         FMT_I: begin
            w[31:20] = v[11:0];
         end
         FMT_S: begin
            w[31:25] = v[11:5];
            w[11:7]  = v[4:0];
         end
         FMT_B: begin
            w[31]    = v[12];
            w[7]     = v[11];
            w[30:25] = v[10:5];
            w[11:8]  = v[4:1];
         end
         FMT_J: begin
            w[31]    = v[20];
            w[19:12] = v[19:12];
            w[20]    = v[11];
            w[30:21] = v[10:1];
         end
         default: begin
            w = b;
         end
      endcase
      return w;
   endfunction

   logic                s1_valid_r;
   logic [1:0]          s1_immsrc_r;
   logic [20:0]         s1_imm_r;
   logic [31:0]         s1_base_r;
   logic                s1_rerr_r;

   logic                s2_valid_r;
   logic [31:0]         s2_instr_r;
   logic                s2_err_r;

   logic [ERRCNT_W-1:0] err_count_r;

   logic                adv1_s;
   logic                adv2_s;
   logic                deliver_s;

   // A stage may take new data when it is empty or its occupant leaves this
   // cycle. in_ready depends only on state and out_ready, never on in_valid.
   assign adv2_s    = ~s2_valid_r | bus.out_ready;
   assign adv1_s    = ~s1_valid_r | adv2_s;
   assign deliver_s = s2_valid_r & bus.out_ready;

   // Stage 1: capture request and classify whether the format can hold it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_r  <= 1'b0;
         s1_immsrc_r <= 2'b00;
         s1_imm_r    <= 21'd0;
         s1_base_r   <= 32'd0;
         s1_rerr_r   <= 1'b0;
      end else if (adv1_s) begin
         s1_valid_r <= bus.in_valid;
         // Payload only moves with a real request, so a bubble leaves it idle.
         if (bus.in_valid) begin
            s1_immsrc_r <= bus.immsrc;
            s1_imm_r    <= bus.imm[20:0];
            s1_base_r   <= bus.base;
            s1_rerr_r   <= range_err(bus.immsrc, bus.imm);
         end
      end
   end

   // Stage 2: pack the stage-1 word into the output register; holds on stall
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid_r <= 1'b0;
         s2_instr_r <= 32'd0;
         s2_err_r   <= 1'b0;
      end else if (adv2_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_instr_r <= pack(s1_immsrc_r, s1_imm_r, s1_base_r);
            s2_err_r   <= s1_rerr_r;
         end
      end
   end

   // Saturating count of error words actually handed to the consumer
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_count_r <= {ERRCNT_W{1'b0}};
      end else if (deliver_s && s2_err_r && (err_count_r != ERR_MAX)) begin
         err_count_r <= err_count_r + ERR_ONE;
      end
   end

   assign bus.in_ready  = adv1_s;
   assign bus.out_valid = s2_valid_r;
   assign bus.instr     = s2_instr_r;
   assign bus.err       = s2_err_r;
   assign bus.err_count = err_count_r;

endmodule
